// File: rtl/bp_me_pkg.sv
// Shared types for the memory-end address region router: stripe modes and the region-table entry.
// The entry struct is declared per-module through a macro so it tracks each instance's widths.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_stripe_none = 2'd0,
    e_stripe_line = 2'd1,
    e_stripe_page = 2'd2,
    e_stripe_rsvd = 2'd3
  } bp_me_stripe_mode_e;

  localparam int bp_me_stripe_bits_width_gp = 3;

endpackage

`define DECLARE_BP_ME_REGION_ENTRY_S(paddr_width_mp, dst_id_width_mp) \
  typedef struct packed { \
    logic                                      en; \
    logic [paddr_width_mp-1:0]                 base; \
    logic [paddr_width_mp-1:0]                 mask; \
    logic [dst_id_width_mp-1:0]                dst_base; \
    bp_me_pkg::bp_me_stripe_mode_e             stripe_mode; \
    logic [bp_me_pkg::bp_me_stripe_bits_width_gp-1:0] stripe_bits; \
  } bp_me_region_entry_s

`define BP_ME_REGION_ENTRY_WIDTH(paddr_width_mp, dst_id_width_mp) \
  (1 + 2*(paddr_width_mp) + (dst_id_width_mp) + 2 + bp_me_pkg::bp_me_stripe_bits_width_gp)

// File: rtl/bp_me_addr_region_match.sv
// One region-table entry: address match and striped destination compute, purely combinational.
module bp_me_addr_region_match
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p  = 40,
  parameter int dst_id_width_p = 6,
  parameter int block_offset_p = 6,
  parameter int page_offset_p  = 12
) (
  input  logic [`BP_ME_REGION_ENTRY_WIDTH(paddr_width_p, dst_id_width_p)-1:0] entry_i,
  input  logic [paddr_width_p-1:0]  paddr_i,
  output logic                      match_o,
  output logic [dst_id_width_p-1:0] dst_o
);

  `DECLARE_BP_ME_REGION_ENTRY_S(paddr_width_p, dst_id_width_p);

  bp_me_region_entry_s       entry;
  logic [paddr_width_p-1:0]  stripe_mask;
  logic [paddr_width_p-1:0]  stripe_field;

  assign entry = entry_i;

  always_comb begin
    match_o     = entry.en & ((paddr_i & entry.mask) == (entry.base & entry.mask));
    // Shifting right zero-fills, so bits past the top of the address read as 0.
    stripe_mask = ~({paddr_width_p{1'b1}} << entry.stripe_bits);
    case (entry.stripe_mode)
      e_stripe_line: stripe_field = (paddr_i >> block_offset_p) & stripe_mask;
      e_stripe_page: stripe_field = (paddr_i >> page_offset_p) & stripe_mask;
      default:       stripe_field = '0;
    endcase
    dst_o = entry.dst_base + dst_id_width_p'(stripe_field);
  end

endmodule

// File: rtl/bp_me_addr_region_router.sv
// CSR-programmed paddr -> destination ID router; lowest matching entry wins, misses use default_dst_p.
// One output register (1-cycle latency); ready_o = ~v_o | yumi_i, result holds while unconsumed.
module bp_me_addr_region_router
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int dst_id_width_p  = 6,
  parameter int num_regions_p   = 8,
  parameter int block_offset_p  = 6,
  parameter int page_offset_p   = 12,
  parameter int default_dst_p   = 0,
  parameter int counter_width_p = 16,
  localparam int idx_width_lp   = (num_regions_p > 1) ? $clog2(num_regions_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       cfg_w_v_i,
  input  logic [idx_width_lp-1:0]    cfg_idx_i,
  input  logic                       cfg_en_i,
  input  logic [paddr_width_p-1:0]   cfg_base_i,
  input  logic [paddr_width_p-1:0]   cfg_mask_i,
  input  logic [dst_id_width_p-1:0]  cfg_dst_base_i,
  input  logic [1:0]                 cfg_stripe_mode_i,
  input  logic [2:0]                 cfg_stripe_bits_i,

  input  logic [paddr_width_p-1:0]   paddr_i,
  input  logic                       v_i,
  output logic                       ready_o,

  output logic [dst_id_width_p-1:0]  dst_id_o,
  output logic                       hit_o,
  output logic                       v_o,
  input  logic                       yumi_i,

  output logic [counter_width_p-1:0] miss_count_o
);

  `DECLARE_BP_ME_REGION_ENTRY_S(paddr_width_p, dst_id_width_p);

  bp_me_region_entry_s       tbl_q [num_regions_p];
  logic [num_regions_p-1:0]  match;
  logic [dst_id_width_p-1:0] entry_dst [num_regions_p];

  logic                       lookup_hit;
  logic [dst_id_width_p-1:0]  lookup_dst;
  logic                       accept;

  logic                       v_q, v_d;
  logic                       hit_q, hit_d;
  logic [dst_id_width_p-1:0]  dst_q, dst_d;
  logic [counter_width_p-1:0] miss_cnt_q, miss_cnt_d;

  for (genvar i = 0; i < num_regions_p; i++) begin : g_region
    bp_me_addr_region_match #(
      .paddr_width_p (paddr_width_p),
      .dst_id_width_p(dst_id_width_p),
      .block_offset_p(block_offset_p),
      .page_offset_p (page_offset_p)
    ) u_match (
      .entry_i(tbl_q[i]),
      .paddr_i(paddr_i),
      .match_o(match[i]),
      .dst_o  (entry_dst[i])
    );
  end

  // Walk high to low so the lowest matching index is the final assignment.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_dst = dst_id_width_p'(default_dst_p);
    for (int i = num_regions_p - 1; i >= 0; i--) begin
      if (match[i]) begin
        lookup_hit = 1'b1;
        lookup_dst = entry_dst[i];
      end
    end
  end

  assign ready_o = ~v_q | yumi_i;
  assign accept  = v_i & ready_o;

  always_comb begin
    v_d        = v_q;
    hit_d      = hit_q;
    dst_d      = dst_q;
    miss_cnt_d = miss_cnt_q;
    if (accept) begin
      v_d   = 1'b1;
      hit_d = lookup_hit;
      dst_d = lookup_dst;
      if (!lookup_hit && !(&miss_cnt_q)) begin
        miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end else if (yumi_i) begin
      v_d = 1'b0;
    end
  end

  // Table writes land at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_regions_p; i++) begin
        tbl_q[i] <= '0;
      end
      v_q        <= 1'b0;
      hit_q      <= 1'b0;
      dst_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      for (int i = 0; i < num_regions_p; i++) begin
        if (cfg_w_v_i && (cfg_idx_i == idx_width_lp'(i))) begin
          tbl_q[i].en          <= cfg_en_i;
          tbl_q[i].base        <= cfg_base_i;
          tbl_q[i].mask        <= cfg_mask_i;
          tbl_q[i].dst_base    <= cfg_dst_base_i;
          tbl_q[i].stripe_mode <= bp_me_stripe_mode_e'(cfg_stripe_mode_i);
          tbl_q[i].stripe_bits <= cfg_stripe_bits_i;
        end
      end
      v_q        <= v_d;
      hit_q      <= hit_d;
      dst_q      <= dst_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign v_o          = v_q;
  assign hit_o        = hit_q;
  assign dst_id_o     = dst_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_bp_me_addr_region_router.sv
// Directed-vector bench for bp_me_addr_region_router with hand-computed destinations.
module tb_bp_me_addr_region_router;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cfg_w_v_i;
  logic [2:0]  cfg_idx_i;
  logic        cfg_en_i;
  logic [39:0] cfg_base_i;
  logic [39:0] cfg_mask_i;
  logic [5:0]  cfg_dst_base_i;
  logic [1:0]  cfg_stripe_mode_i;
  logic [2:0]  cfg_stripe_bits_i;
  logic [39:0] paddr_i;
  logic        v_i;
  logic        ready_o;
  logic [5:0]  dst_id_o;
  logic        hit_o;
  logic        v_o;
  logic        yumi_i;
  logic [15:0] miss_count_o;

  int total = 0;
  int bad   = 0;
  int exp_miss = 0;

  bp_me_addr_region_router dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .cfg_w_v_i        (cfg_w_v_i),
    .cfg_idx_i        (cfg_idx_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_base_i       (cfg_base_i),
    .cfg_mask_i       (cfg_mask_i),
    .cfg_dst_base_i   (cfg_dst_base_i),
    .cfg_stripe_mode_i(cfg_stripe_mode_i),
    .cfg_stripe_bits_i(cfg_stripe_bits_i),
    .paddr_i          (paddr_i),
    .v_i              (v_i),
    .ready_o          (ready_o),
    .dst_id_o         (dst_id_o),
    .hit_o            (hit_o),
    .v_o              (v_o),
    .yumi_i           (yumi_i),
    .miss_count_o     (miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [2:0] idx, input logic en, input logic [39:0] base,
                         input logic [39:0] mask, input logic [5:0] dst, input logic [1:0] mode,
                         input logic [2:0] bits);
    cfg_idx_i         = idx;
    cfg_en_i          = en;
    cfg_base_i        = base;
    cfg_mask_i        = mask;
    cfg_dst_base_i    = dst;
    cfg_stripe_mode_i = mode;
    cfg_stripe_bits_i = bits;
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic en, input logic [39:0] base,
                        input logic [39:0] mask, input logic [5:0] dst, input logic [1:0] mode,
                        input logic [2:0] bits);
    set_cfg(idx, en, base, mask, dst, mode, bits);
    cfg_w_v_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_w_v_i = 1'b0;
  endtask

  // Issue one request with v_o idle, check the registered result, then consume it.
  task automatic req(input string tag, input logic [39:0] addr, input logic [5:0] exp_dst,
                     input logic exp_hit);
    paddr_i = addr;
    v_i     = 1'b1;
    yumi_i  = 1'b0;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    if (!exp_hit) exp_miss++;
    chk({tag, ".v"},    64'(v_o),          64'd1);
    chk({tag, ".dst"},  64'(dst_id_o),     64'(exp_dst));
    chk({tag, ".hit"},  64'(hit_o),        64'(exp_hit));
    chk({tag, ".miss"}, 64'(miss_count_o), 64'(exp_miss));
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b1;
    cfg_w_v_i = 1'b0;
    set_cfg(3'd0, 1'b0, 40'h0, 40'h0, 6'd0, 2'd0, 3'd0);
    paddr_i = '0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("rst.v",     64'(v_o),          64'd0);
    chk("rst.dst",   64'(dst_id_o),     64'd0);
    chk("rst.hit",   64'(hit_o),        64'd0);
    chk("rst.miss",  64'(miss_count_o), 64'd0);
    chk("rst.ready", 64'(ready_o),      64'd1);

    req("empty", 40'h00_8000_0040, 6'd0, 1'b0);

    // Line striping over 4 destinations starting at 4.
    cfg_wr(3'd0, 1'b1, 40'h00_8000_0000, 40'hFF_8000_0000, 6'd4, 2'd1, 3'd2);
    req("line0", 40'h00_8000_0000, 6'd4, 1'b1);
    req("line1", 40'h00_8000_0040, 6'd5, 1'b1);
    req("line2", 40'h00_8000_0080, 6'd6, 1'b1);
    req("line3", 40'h00_8000_00C0, 6'd7, 1'b1);
    req("line4", 40'h00_8000_0100, 6'd4, 1'b1);

    // Overlapping entries: lowest index wins until it is disabled.
    cfg_wr(3'd1, 1'b1, 40'h00_0010_0000, 40'hFF_FFF0_0000, 6'd9,  2'd0, 3'd0);
    cfg_wr(3'd3, 1'b1, 40'h00_0010_0000, 40'hFF_FFF0_0000, 6'd12, 2'd0, 3'd0);
    req("prio", 40'h00_0010_0000, 6'd9, 1'b1);
    cfg_wr(3'd1, 1'b0, 40'h00_0010_0000, 40'hFF_FFF0_0000, 6'd9,  2'd0, 3'd0);
    req("prio_dis", 40'h00_0010_0000, 6'd12, 1'b1);

    // Page striping with wraparound: 62 + 3 = 65 -> 1.
    cfg_wr(3'd2, 1'b1, 40'h00_2000_0000, 40'hFF_F000_0000, 6'd62, 2'd2, 3'd2);
    req("page_wrap", 40'h00_2000_3000, 6'd1, 1'b1);

    req("miss2", 40'h00_4000_0000, 6'd0, 1'b0);

    // Backpressure: result held, second request stalls.
    paddr_i = 40'h00_8000_0040;
    v_i     = 1'b1;
    yumi_i  = 1'b0;
    @(posedge clk_i); #1;
    paddr_i = 40'h00_8000_0080;
    for (int c = 0; c < 3; c++) begin
      chk("bp.ready", 64'(ready_o),  64'd0);
      chk("bp.v",     64'(v_o),      64'd1);
      chk("bp.dst",   64'(dst_id_o), 64'd5);
      @(posedge clk_i); #1;
    end
    chk("bp.hold_dst", 64'(dst_id_o), 64'd5);
    yumi_i = 1'b1;
    #1;
    chk("bp.ready_yumi", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;
    v_i    = 1'b0;
    yumi_i = 1'b0;
    chk("bp.next_v",   64'(v_o),      64'd1);
    chk("bp.next_dst", 64'(dst_id_o), 64'd6);
    chk("bp.next_hit", 64'(hit_o),    64'd1);
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    chk("bp.drained", 64'(v_o), 64'd0);

    // Config write in the acceptance cycle: lookup uses the old entry 0 mapping.
    set_cfg(3'd0, 1'b1, 40'h00_8000_0000, 40'hFF_8000_0000, 6'd20, 2'd0, 3'd0);
    cfg_w_v_i = 1'b1;
    paddr_i   = 40'h00_8000_0040;
    v_i       = 1'b1;
    @(posedge clk_i); #1;
    cfg_w_v_i = 1'b0;
    v_i       = 1'b0;
    chk("cfgcoin.dst", 64'(dst_id_o), 64'd5);
    chk("cfgcoin.hit", 64'(hit_o),    64'd1);
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    req("newmap", 40'h00_8000_0040, 6'd20, 1'b1);

    // Reset while a miss result is held.
    paddr_i = 40'h00_4000_0000;
    v_i     = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    exp_miss++;
    chk("prerst.v",    64'(v_o),          64'd1);
    chk("prerst.miss", 64'(miss_count_o), 64'(exp_miss));
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    exp_miss = 0;
    chk("midrst.v",     64'(v_o),          64'd0);
    chk("midrst.miss",  64'(miss_count_o), 64'd0);
    chk("midrst.ready", 64'(ready_o),      64'd1);
    chk("midrst.dst",   64'(dst_id_o),     64'd0);
    chk("midrst.hit",   64'(hit_o),        64'd0);
    req("postrst", 40'h00_8000_0000, 6'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_me_addr_region_router.md
# bp_me_addr_region_router

Run-time programmable physical-address-to-destination-ID router for the memory-end request path. It generalises the fixed address-to-CCE-ID map: destination regions, their target ID ranges and their striping granularity are held in a CSR-written region table, so no elaboration-time address map is needed. Lookups are pipelined behind a valid/ready handshake. The block sits between the LCE/IO request source and the wormhole network-injection logic, and supplies the destination ID for every outgoing request.

## Interface
- paddr_width_p, 40: physical address width
- dst_id_width_p, 6: destination ID width (CCE/IO/accelerator ID space)
- num_regions_p, 8: region table entries (≥1)
- block_offset_p, 6: log2 of cache block bytes (line striping)
- page_offset_p, 12: log2 of page bytes (page striping)
- default_dst_p, 0: destination ID returned on table miss
- counter_width_p, 16: miss-counter width
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cfg_w_v_i  in  1  region-table write strobe
- cfg_idx_i  in  clog2(num_regions_p)  entry index
- cfg_en_i  in  1  entry enable
- cfg_base_i / cfg_mask_i  in  paddr_width_p  match base and match mask
- cfg_dst_base_i  in  dst_id_width_p  first destination ID of the entry
- cfg_stripe_mode_i  in  2  0 none, 1 cache line, 2 page, 3 reserved (treated as none)
- cfg_stripe_bits_i  in  3  log2 of the number of destinations striped over
- paddr_i  in  paddr_width_p  request address
- v_i  in  1  request valid
- ready_o  out  1  block can accept a request
- dst_id_o  out  dst_id_width_p  routed destination ID
- hit_o  out  1  1 = a region matched; 0 = default_dst_p was used
- v_o  out  1  result valid
- yumi_i  in  1  consumer takes the result (only legal while v_o is 1)
- miss_count_o  out  counter_width_p  saturating count of misses

## Operation
- Entry i matches when en[i] is 1 and (paddr_i & mask[i]) == (base[i] & mask[i]). When several entries match, the lowest index wins.
- Destination on hit, computed modulo 2^dst_id_width_p:
  - mode none, or stripe_bits = 0: dst_base.
  - mode line: dst_base + paddr[block_offset_p +: stripe_bits].
  - mode page: dst_base + paddr[page_offset_p +: stripe_bits].
  - Address bits beyond paddr_width_p read as 0.
- On miss: dst_id_o = default_dst_p, hit_o = 0, and miss_count_o increments when the result is accepted into the output register. The counter saturates at all-ones.
- Config write: takes effect at the clock edge. A request accepted in the same cycle is looked up against the pre-write table.
- Reset state: all entries disabled (base, mask and dst_base are 0), v_o = 0, dst_id_o = 0, hit_o = 0, miss_count_o = 0, ready_o = 1.

## Timing
- One output register; latency is 1 cycle from acceptance (v_i & ready_o) to v_o.
- ready_o = ~v_o | yumi_i. Back-to-back throughput is 1 request per cycle while yumi_i is held high.
- While v_o = 1 and yumi_i = 0, dst_id_o and hit_o hold stable.
- Reset asserted mid-operation drops the held result. ready_o = 1 on the first cycle after reset deasserts.
- A cfg write while a result is held does not alter the held result.

## Structure
- Shared package (bp_me_pkg): stripe-mode enum, bp_me_region_entry_s struct (en, base, mask, dst_base, stripe_mode, stripe_bits), and a width macro for that struct.
- Sub-module bp_me_addr_region_match: combinational per-entry match plus destination compute, instantiated num_regions_p times. The top level holds the table registers, a priority encoder, the output register and the counter.

## Test plan
- Reset, then paddr 0x8000_0040 with the table empty → v_o one cycle later, dst_id_o = 0, hit_o = 0, miss_count_o = 1.
- Entry 0: base 0x8000_0000, mask 0xFF_8000_0000, dst_base 4, line mode, 2 bits. Requests 0x8000_0000 / 0x8000_0040 / 0x8000_0080 / 0x8000_00C0 / 0x8000_0100 → dst_id_o 4 / 5 / 6 / 7 / 4, all with hit_o = 1.
- Entries 1 and 3 both match 0x10_0000; entry 1 has dst_base 9, entry 3 has dst_base 12 → dst_id_o = 9. Disable entry 1 → dst_id_o = 12.
- Page mode, dst_base 62, 2 bits, address page index 3 → dst_id_o = 1, wrapped modulo 64.
- Hold yumi_i = 0 for 3 cycles with v_i = 1 → ready_o = 0, dst_id_o stable, no second acceptance. Then pulse yumi_i → the next result appears the following cycle.
- Assert reset with v_o = 1 → v_o = 0 and miss_count_o = 0 next cycle. Separately, a cfg write coincident with acceptance → the old mapping is returned.
